wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback-stage arbiter directly upstream of the general purpose register file; sole driver of its single write port (we_, wr_addr, wr_data).
- Merges three result sources: the in-order pipeline result (no backpressure), the load/store unit (LSU) and the multiply/divide unit (MDU); both units are long-latency with valid/ready.
- Holds a per-register busy scoreboard for outstanding long-latency destinations; decode uses it to stall.

Parameters:
WORD_WIDTH, 32, data width of results and write port
GPR_ADDR_WIDTH, 5, register address width
GPR_NUM, 32, number of registers tracked by the scoreboard

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
pipe_we  in  1  pipeline result valid (1 = write request)
pipe_addr  in  GPR_ADDR_WIDTH  pipeline destination
pipe_data  in  WORD_WIDTH  pipeline result
lsu_valid  in  1  LSU result valid
lsu_addr  in  GPR_ADDR_WIDTH  LSU destination
lsu_data  in  WORD_WIDTH  LSU result
lsu_ready  out  1  LSU result accepted this cycle
mdu_valid  in  1  MDU result valid
mdu_addr  in  GPR_ADDR_WIDTH  MDU destination
mdu_data  in  WORD_WIDTH  MDU result
mdu_ready  out  1  MDU result accepted this cycle
issue_valid  in  1  long-latency op issued this cycle
issue_addr  in  GPR_ADDR_WIDTH  its destination
rs1_addr  in  GPR_ADDR_WIDTH  decode query 1
rs2_addr  in  GPR_ADDR_WIDTH  decode query 2
rs1_busy  out  1  rs1_addr has an outstanding write
rs2_busy  out  1  rs2_addr has an outstanding write
we_  out  1  GPR write enable, active low (0 = write)
wr_addr  out  GPR_ADDR_WIDTH  GPR write address
wr_data  out  WORD_WIDTH  GPR write data

Behaviour:
- Reset (rst=1 at a clk edge): we_=1, wr_addr=0, wr_data=0, busy vector all 0, rr pointer=0 (LSU preferred). lsu_ready/mdu_ready are combinational and stay 0 while rst=1. Reset mid-handshake drops the result; no write is issued.
- Port claim: pipe_we=1 with pipe_addr!=0 claims the port. pipe_we=1 with pipe_addr=0 does not claim it.
- Grant (combinational, only when the port is unclaimed):
  - one long source valid -> it is granted;
  - both valid -> the rr-preferred source is granted, and the rr pointer switches to the other source on the next edge;
  - a single grant sets the rr pointer to the non-granted source.
- lsu_ready/mdu_ready = grant; they may depend on the source's own valid. Handshake = valid & ready.
- A valid source must hold addr/data stable until its handshake.
- Write port is registered, 1 cycle latency. At the edge after a claim or handshake: we_=0 with that addr/data for exactly one cycle, else we_=1.
  - wr_addr/wr_data hold their last value when we_=1.
  - A handshake with addr=0 is accepted but produces we_=1 (x0 never written).
- Scoreboard:
  - issue_valid with issue_addr!=0 sets busy[issue_addr] at the edge.
  - A handshake clears busy[addr] at the same edge the write is registered. GPR read bypass makes the data visible in the cycle busy reads 0.
  - Set and clear of the same address in one cycle: set wins.
  - A pipeline write to a busy register does not change busy (upstream stalls; not checked here).
- rsN_busy = busy[rsN_addr], combinational; address 0 always reads 0.
- Steady state: no source is starved for more than 1 cycle beyond the pipeline-occupied cycles.

Test Plan:
- Reset then idle -> we_=1, wr_addr=0, wr_data=0, both busy=0 and both readys=0 for 5 cycles.
- pipe_we=1, addr=5, data=0xDEADBEEF at cycle N -> we_=0, wr_addr=5, wr_data=0xDEADBEEF in cycle N+1 only; LSU valid same cycle sees lsu_ready=0 at N and ready=1 at N+1.
- issue_valid addr=7; rs1_addr=7 -> rs1_busy=1 from next cycle. MDU valid addr=7 data=0x12 -> mdu_ready=1 same cycle; next cycle we_=0, addr=7, data=0x12, rs1_busy=0.
- LSU (addr=3) and MDU (addr=4) valid together from reset -> grants LSU then MDU on consecutive cycles; writes to 3 then 4.
- Continuous LSU and MDU valid for 6 cycles -> grants alternate L,M,L,M,L,M.
- pipe_we=1 addr=0 with LSU valid addr=0 data=0x55 -> lsu_ready=1, no write (we_ stays 1).
- issue_valid addr=9 and MDU handshake addr=9 in the same cycle -> busy[9] stays 1.
- rst=1 asserted while lsu_valid=1 -> lsu_ready=0, no write, busy cleared.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline, LSU and MDU results onto the single GPR
// write port and tracks registers with outstanding long-latency writes.
module wb_arbiter #(
  parameter int WORD_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int GPR_NUM        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_we,
  input  logic [GPR_ADDR_WIDTH-1:0] pipe_addr,
  input  logic [WORD_WIDTH-1:0]     pipe_data,
  input  logic                      lsu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_addr,
  input  logic [WORD_WIDTH-1:0]     lsu_data,
  output logic                      lsu_ready,
  input  logic                      mdu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] mdu_addr,
  input  logic [WORD_WIDTH-1:0]     mdu_data,
  output logic                      mdu_ready,
  input  logic                      issue_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] issue_addr,
  input  logic [GPR_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [GPR_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      we_,
  output logic [GPR_ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0]     wr_data
);

  typedef enum logic {PREF_LSU = 1'b0, PREF_MDU = 1'b1} rr_t;

  rr_t                       rr_q, rr_d;
  logic                      claim_p0;
  logic                      grant_lsu_p0;
  logic                      grant_mdu_p0;
  logic                      sel_vld_p0;
  logic [GPR_ADDR_WIDTH-1:0] sel_addr_p0;
  logic [WORD_WIDTH-1:0]     sel_data_p0;
  logic [GPR_NUM-1:0]        busy_q, busy_d, busy_set, busy_clr;

  always_ff @(posedge clk) begin
    if (rst) rr_q <= PREF_LSU;
    else     rr_q <= rr_d;
  end

  // Pipeline results never stall, so long-latency sources only get idle cycles.
  always_comb begin
    rr_d         = rr_q;
    grant_lsu_p0 = 1'b0;
    grant_mdu_p0 = 1'b0;
    claim_p0     = pipe_we && (pipe_addr != '0);
    if (!rst && !claim_p0) begin
      if (lsu_valid && (!mdu_valid || rr_q == PREF_LSU)) grant_lsu_p0 = 1'b1;
      else if (mdu_valid)                                 grant_mdu_p0 = 1'b1;
    end
    if (grant_lsu_p0)      rr_d = PREF_MDU;
    else if (grant_mdu_p0) rr_d = PREF_LSU;
  end

  assign lsu_ready = grant_lsu_p0;
  assign mdu_ready = grant_mdu_p0;

  always_comb begin
    sel_vld_p0  = 1'b0;
    sel_addr_p0 = pipe_addr;
    sel_data_p0 = pipe_data;
    if (claim_p0) begin
      sel_vld_p0 = 1'b1;
    end else if (grant_lsu_p0) begin
      sel_vld_p0  = (lsu_addr != '0);
      sel_addr_p0 = lsu_addr;
      sel_data_p0 = lsu_data;
    end else if (grant_mdu_p0) begin
      sel_vld_p0  = (mdu_addr != '0);
      sel_addr_p0 = mdu_addr;
      sel_data_p0 = mdu_data;
    end
  end

  // ---- p0 -> p1: registered GPR write port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      we_     <= 1'b1;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      we_ <= !sel_vld_p0;
      if (sel_vld_p0) begin
        wr_addr <= sel_addr_p0;
        wr_data <= sel_data_p0;
      end
    end
  end

  // A new issue to the register being retired must win, hence set after clear.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue_valid && issue_addr != '0) busy_set[issue_addr] = 1'b1;
    if (grant_lsu_p0)                    busy_clr[lsu_addr]   = 1'b1;
    if (grant_mdu_p0)                    busy_clr[mdu_addr]   = 1'b1;
    busy_d = (busy_q & ~busy_clr) | busy_set;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rs1_busy = (rs1_addr != '0) && busy_q[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) && busy_q[rs2_addr];

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the arbitration and scoreboard rules.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        issue_valid;
  logic [4:0]  issue_addr, rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        we_;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  wb_arbiter #(.WORD_WIDTH(32), .GPR_ADDR_WIDTH(5), .GPR_NUM(32)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we_(we_), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Reference model state
  bit          busy_m [32];
  bit          mdu_turn;      // 1 when the MDU should win a tie
  logic        exp_we_n = 1'b1;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  bit          last_gl, last_gm;

  task automatic set_idle();
    rst = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
    issue_valid = 1'b0; issue_addr = '0; rs1_addr = '0; rs2_addr = '0;
  endtask

  // One clock: check combinational outputs, advance the model across the edge,
  // check the write port, then retire handshaken sources and one-shot pulses.
  task automatic step();
    bit claim, gl, gm;
    #1;
    claim = pipe_we && pipe_addr != 0;
    gl = 1'b0; gm = 1'b0;
    if (!rst && !claim) begin
      if (lsu_valid && mdu_valid) begin
        if (mdu_turn) gm = 1'b1; else gl = 1'b1;
      end else begin
        gl = lsu_valid;
        gm = mdu_valid;
      end
    end
    chk("lsu_ready", lsu_ready, gl);
    chk("mdu_ready", mdu_ready, gm);
    chk("rs1_busy", rs1_busy, (rs1_addr != 0) && busy_m[rs1_addr]);
    chk("rs2_busy", rs2_busy, (rs2_addr != 0) && busy_m[rs2_addr]);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_we_n = 1'b1; exp_addr = '0; exp_data = '0; mdu_turn = 1'b0;
      foreach (busy_m[i]) busy_m[i] = 1'b0;
    end else begin
      exp_we_n = 1'b1;
      if (claim) begin
        exp_we_n = 1'b0; exp_addr = pipe_addr; exp_data = pipe_data;
      end else if (gl && lsu_addr != 0) begin
        exp_we_n = 1'b0; exp_addr = lsu_addr; exp_data = lsu_data;
      end else if (gm && mdu_addr != 0) begin
        exp_we_n = 1'b0; exp_addr = mdu_addr; exp_data = mdu_data;
      end
      if (gl) busy_m[lsu_addr] = 1'b0;
      if (gm) busy_m[mdu_addr] = 1'b0;
      if (issue_valid && issue_addr != 0) busy_m[issue_addr] = 1'b1;
      busy_m[0] = 1'b0;
      if (gl) mdu_turn = 1'b1;
      else if (gm) mdu_turn = 1'b0;
    end
    chk("we_", we_, exp_we_n);
    chk("wr_addr", wr_addr, exp_addr);
    chk("wr_data", wr_data, exp_data);
    last_gl = gl; last_gm = gm;
    if (gl || rst) lsu_valid = 1'b0;
    if (gm || rst) mdu_valid = 1'b0;
    pipe_we = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_we", we_, 1'b1);
    chk("idle_wr_data", wr_data, 32'h0);

    // Pipeline write blocks a simultaneous LSU result for one cycle
    pipe_we = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEADBEEF;
    lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'h33;
    #1 chk("lsu_blocked", lsu_ready, 1'b0);
    step();
    chk("pipe_we", we_, 1'b0);
    chk("pipe_addr", wr_addr, 32'd5);
    chk("pipe_data", wr_data, 32'hDEADBEEF);
    #1 chk("lsu_after_pipe", lsu_ready, 1'b1);
    step();
    chk("lsu_wr_addr", wr_addr, 32'd3);
    step();
    chk("one_cycle_we", we_, 1'b1);

    // Scoreboard set by issue, cleared by MDU writeback
    issue_valid = 1'b1; issue_addr = 5'd7; rs1_addr = 5'd7;
    step();
    chk("busy7_set", rs1_busy, 1'b1);
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h12;
    #1 chk("mdu_ready7", mdu_ready, 1'b1);
    step();
    chk("mdu7_addr", wr_addr, 32'd7);
    chk("mdu7_data", wr_data, 32'h12);
    chk("busy7_clr", rs1_busy, 1'b0);

    // Tie from reset: LSU first, then MDU, then strict alternation
    rst = 1'b1; step(); rst = 1'b0;
    lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'hA3;
    mdu_valid = 1'b1; mdu_addr = 5'd4; mdu_data = 32'hA4;
    step();
    chk("tie_first_lsu", wr_addr, 32'd3);
    step();
    chk("tie_then_mdu", wr_addr, 32'd4);
    for (int i = 0; i < 6; i++) begin
      lsu_valid = 1'b1; mdu_valid = 1'b1;
      step();
      chk("alternate", wr_addr, (i % 2 == 0) ? 32'd3 : 32'd4);
    end
    lsu_valid = 1'b0; mdu_valid = 1'b0;

    // x0 writes: pipeline to x0 does not claim, LSU to x0 is accepted silently
    pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'hFF;
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h55;
    #1 chk("x0_lsu_ready", lsu_ready, 1'b1);
    step();
    chk("x0_no_write", we_, 1'b1);

    // Same-cycle set and clear of one register: set wins
    issue_valid = 1'b1; issue_addr = 5'd9; rs2_addr = 5'd9;
    step();
    issue_valid = 1'b1; issue_addr = 5'd9;
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h99;
    step();
    chk("busy9_kept", rs2_busy, 1'b1);
    step();

    // Reset in the middle of an offered LSU result
    rst = 1'b1; lsu_valid = 1'b1; lsu_addr = 5'd6; lsu_data = 32'h66;
    #1 chk("rst_lsu_ready", lsu_ready, 1'b0);
    step();
    rst = 1'b0;
    chk("rst_no_write", we_, 1'b1);
    chk("rst_busy_clr", rs2_busy, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (!lsu_valid && $urandom_range(0, 2) == 0) begin
        lsu_valid = 1'b1; lsu_addr = 5'($urandom_range(0, 7)); lsu_data = $urandom;
      end
      if (!mdu_valid && $urandom_range(0, 2) == 0) begin
        mdu_valid = 1'b1; mdu_addr = 5'($urandom_range(0, 7)); mdu_data = $urandom;
      end
      pipe_we     = ($urandom_range(0, 3) == 0);
      pipe_addr   = 5'($urandom_range(0, 7));
      pipe_data   = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_addr  = 5'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      rst         = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
